// File: rtl/tt_event_capture.sv
// Time-tag event capture: PPS-synchronised tick counter, PPS period measurement and trigger timestamp FIFO.
// Optional macro TT_SECONDS_COUNT_EN adds a PPS seconds counter that is stored with each tag.
module tt_event_capture #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pps,
  input  logic                     trig,
  input  logic                     tag_ready,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         tag_data,
  output logic                     tag_valid,
  output logic [$clog2(DEPTH):0]   tag_fill,
  output logic                     overflow,
  output logic [WIDTH-1:0]         pps_period,
  output logic                     pps_seen
`ifdef TT_SECONDS_COUNT_EN
  ,
  output logic [31:0]              seconds,
  output logic [31:0]              tag_sec
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef TT_SECONDS_COUNT_EN
  localparam int EW = WIDTH + 32;
`else
  localparam int EW = WIDTH;
`endif

  logic             s1, s2, s3;
  logic             pps_edge;
  logic [WIDTH-1:0] tick_count;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    wr_entry, head;
  logic             full, pop, push, drop;

  assign pps_edge = s2 & ~s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pps;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Period is the count including the clearing edge itself, so edges N apart give N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_count <= '0;
      pps_period <= '0;
      pps_seen   <= 1'b0;
    end else if (pps_edge) begin
      tick_count <= '0;
      pps_period <= (&tick_count) ? '1 : tick_count + 1'b1;
      pps_seen   <= 1'b1;
    end else if (!(&tick_count)) begin
      tick_count <= tick_count + 1'b1;
    end
  end

`ifdef TT_SECONDS_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         seconds <= '0;
    else if (pps_edge) seconds <= seconds + 32'd1;
  end
  assign wr_entry = {seconds, tick_count};
  assign tag_sec  = head[EW-1:WIDTH];
`else
  assign wr_entry = tick_count;
`endif

  // Extra pointer MSB separates full from empty.
  assign tag_fill  = wr_ptr - rd_ptr;
  assign tag_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = tag_valid & tag_ready;
  assign push      = trig & (~full | pop);
  assign drop      = trig & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign tag_data = head[WIDTH-1:0];

endmodule

// File: tb/tb_tt_event_capture.sv
// Bench for tt_event_capture: scoreboard of expected tags plus a table of trigger offsets after PPS.
module tb_tt_event_capture;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1, pps = 1'b0, trig = 1'b0, tag_ready = 1'b0, ovf_clr = 1'b0;
  logic [WIDTH-1:0] tag_data, pps_period;
  logic tag_valid, overflow, pps_seen;
  logic [$clog2(DEPTH):0] tag_fill;
`ifdef TT_SECONDS_COUNT_EN
  logic [31:0] seconds, tag_sec;
`endif

  tt_event_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pps(pps), .trig(trig), .tag_ready(tag_ready), .ovf_clr(ovf_clr),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_fill(tag_fill), .overflow(overflow),
    .pps_period(pps_period), .pps_seen(pps_seen)
`ifdef TT_SECONDS_COUNT_EN
    , .seconds(seconds), .tag_sec(tag_sec)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [63:0] sb[$];
  logic [31:0] m_tick = 0, m_period = 0, m_sec = 0;
  logic m_seen = 0, m_ovf = 0, m_clr = 0;

  typedef struct { int dly; logic [31:0] exp; } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge: update the reference model from the inputs, then compare after the edge.
  task automatic step();
    logic [63:0] h;
    logic drop;
    if (sb.size() > 0 && tag_ready) begin
      h = sb.pop_front();
      chk("sb_tag", 64'(tag_data), {32'd0, h[31:0]});
`ifdef TT_SECONDS_COUNT_EN
      chk("sb_sec", 64'(tag_sec), {32'd0, h[63:32]});
`endif
    end
    drop = trig && (sb.size() >= DEPTH);
    if (trig && !drop) sb.push_back({m_sec, m_tick});
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (m_clr) begin
      m_period = m_tick + 1;
      m_tick = 0;
      m_seen = 1'b1;
      m_sec = m_sec + 1;
      m_clr = 1'b0;
    end else begin
      m_tick = m_tick + 1;
    end
    @(posedge clk); #1;
    chk("valid", 64'(tag_valid), 64'(sb.size() > 0));
    chk("fill", 64'(tag_fill), 64'(sb.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("period", 64'(pps_period), 64'(m_period));
    chk("seen", 64'(pps_seen), 64'(m_seen));
`ifdef TT_SECONDS_COUNT_EN
    chk("seconds", 64'(seconds), 64'(m_sec));
`endif
  endtask

  // One-cycle PPS pulse; the edge after this task returns is the clearing edge.
  task automatic pps_pulse();
    pps = 1'b1; step();
    pps = 1'b0; step();
    m_clr = 1'b1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_tick = 0; m_period = 0; m_sec = 0;
    m_seen = 0; m_ovf = 0; m_clr = 0;
  endtask

  initial begin
    tbl[0] = '{11, 32'd10};
    tbl[1] = '{1,  32'd0};
    tbl[2] = '{3,  32'd2};
    tbl[3] = '{40, 32'd39};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("rst_period", 64'(pps_period), 64'd0);
    chk("rst_seen", 64'(pps_seen), 64'd0);
    chk("rst_valid", 64'(tag_valid), 64'd0);

    // PPS edges 100 clocks apart
    repeat (5) step();
    chk("pre_seen", 64'(pps_seen), 64'd0);
    pps_pulse(); step();
    chk("seen1", 64'(pps_seen), 64'd1);
    repeat (97) step();
    pps_pulse(); step();
    chk("period100", 64'(pps_period), 64'd100);

    // Trigger offsets after a clearing edge
    for (int i = 0; i < 4; i++) begin
      pps_pulse(); step();
      repeat (tbl[i].dly - 1) step();
      trig = 1'b1; step(); trig = 1'b0;
      chk("tbl_valid", 64'(tag_valid), 64'd1);
      chk("tbl_tag", 64'(tag_data), 64'(tbl[i].exp));
      tag_ready = 1'b1; step(); tag_ready = 1'b0;
      chk("tbl_empty", 64'(tag_fill), 64'd0);
    end

    // Trigger coincident with the clearing edge at tick 57
    pps_pulse(); step();
    repeat (55) step();
    pps_pulse();
    trig = 1'b1; step(); trig = 1'b0;
    chk("coinc_tag", 64'(tag_data), 64'd57);
    step(); step();
    trig = 1'b1; step(); trig = 1'b0;
    tag_ready = 1'b1; step();
    chk("after_coinc", 64'(tag_data), 64'd2);
    step(); tag_ready = 1'b0;

    // Six triggers into a four-deep FIFO
    trig = 1'b1; repeat (6) step();
    chk("full_fill", 64'(tag_fill), 64'd4);
    chk("full_ovf", 64'(overflow), 64'd1);
    ovf_clr = 1'b1; step();
    chk("set_wins", 64'(overflow), 64'd1);
    trig = 1'b0; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop
    trig = 1'b1; tag_ready = 1'b1; step();
    chk("pp_fill", 64'(tag_fill), 64'd4);
    chk("pp_ovf", 64'(overflow), 64'd0);
    trig = 1'b0; repeat (4) step();
    chk("drained", 64'(tag_valid), 64'd0);

    // Empty with push and pop: push must land
    trig = 1'b1; step(); trig = 1'b0;
    chk("empty_pp", 64'(tag_fill), 64'd1);
    step(); tag_ready = 1'b0;

    // Asynchronous reset with entries queued
    trig = 1'b1; repeat (3) step(); trig = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(tag_valid), 64'd0);
    chk("ar_fill", 64'(tag_fill), 64'd0);
    chk("ar_seen", 64'(pps_seen), 64'd0);
    chk("ar_period", 64'(pps_period), 64'd0);
`ifdef TT_SECONDS_COUNT_EN
    chk("ar_sec", 64'(seconds), 64'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    trig = 1'b1; step(); trig = 1'b0;
    chk("ar_tick0", 64'(tag_data), 64'd0);
    tag_ready = 1'b1; step(); tag_ready = 1'b0;
    repeat (3) begin pps_pulse(); step(); step(); end
`ifdef TT_SECONDS_COUNT_EN
    chk("sec3", 64'(seconds), 64'd3);
    trig = 1'b1; step(); trig = 1'b0;
    chk("tag_sec3", 64'(tag_sec), 64'd3);
    tag_ready = 1'b1; step(); tag_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
